mul_share_arbiter: RTL
======================

Name: mul_share_arbiter

Overview:
- Shares one combinational 4x4 unsigned multiplier (Multiplier_4) among N_REQ smart-home requesters, e.g. power-meter, lighting-dimmer and thermostat scaling logic.
- Arbitrates requests round-robin, registers the winner's operands onto the multiplier inputs, captures the 8-bit product, and holds it with a tag until the consumer acknowledges.
- Sits between the requester blocks and a single Multiplier_4 instance that lives outside this block.

Parameters:
- N_REQ, 3, number of requesters; legal range 2..4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; held high with operands stable until that requester's gnt is seen.
- a_in  in  4*N_REQ  operand A; requester k uses bits [4k+3:4k].
- b_in  in  4*N_REQ  operand B; same packing as a_in.
- gnt  out  N_REQ  one-hot, one-cycle pulse: operands of that requester were captured.
- mul_I1  out  4  registered operand A to external multiplier I1.
- mul_I2  out  4  registered operand B to external multiplier I2.
- mul_P  in  8  product from external multiplier P.
- res_valid  out  1  result held and valid.
- res_id  out  2  index of the requester owning the result.
- res_data  out  8  product.
- res_ack  in  1  consumer accepts the result; sampled only in DONE.
- busy  out  1  high in ISSUE and DONE.

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=N_REQ-1, so req[0] has highest priority first.
- FSM states: IDLE, ISSUE, DONE.
- IDLE, req==0: stay in IDLE; outputs unchanged, gnt=0.
- IDLE, req!=0, at the edge:
  - Winner = first set bit searching from (last_grant+1) mod N_REQ upward with wrap.
  - gnt <= onehot(winner); mul_I1/mul_I2 <= winner's a/b slice; res_id <= winner; state <= ISSUE.
- ISSUE (one cycle; the multiplier settles combinationally):
  - res_data <= mul_P; res_valid <= 1; gnt <= 0; last_grant <= winner; state <= DONE.
- DONE:
  - res_valid, res_data, res_id and mul_I1/mul_I2 held stable.
  - On res_ack=1: res_valid <= 0; state <= IDLE.
  - The next arbitration happens at the edge after the return to IDLE. No bypass from DONE to a new grant.
- Latency: req sampled at edge t; gnt high during t..t+1; res_valid high from edge t+1. Back-to-back throughput is at best 1 result per 3 cycles with res_ack held high.
- res_ack outside DONE is ignored. req bits are ignored outside IDLE; no grant is lost, the request simply waits.
- Arithmetic: unsigned 4x4 -> 8 bit, never overflows (max 15*15=225). res_data is the captured mul_P exactly; the block does no arithmetic itself.
- Fairness: a continuously requesting agent waits at most N_REQ-1 other grants.
- Requester contract: drop req, or change operands, only after its gnt pulse. A req still high when the block returns to IDLE is treated as a new request.
- Reset mid-operation (ISSUE or DONE): pending result discarded; all registers return to reset values at that edge.

Test Plan:
- Single request: req=001, a0=3, b0=5 -> gnt=001 for 1 cycle; mul_I1=3, mul_I2=5; res_valid=1 with res_id=0, res_data=15 two edges after req sampled; held until res_ack; valid drops the edge after ack.
- Max operands: req=100, a2=15, b2=15 -> res_id=2, res_data=225 (0xE1).
- Contention with res_ack tied high: req=111 held, operands (2,3), (4,5), (6,7) -> grant order 0,1,2,0 …; results 6, 20, 42; one result every 3 cycles.
- Rotation: after a grant to 1, req=011 -> next grant goes to 0 (wrap from last_grant+1=2); req=110 -> grant goes to 2.
- Stall: res_ack=0 for 10 cycles in DONE while req=010 -> no gnt; res_data stable; busy=1. After ack, gnt=010 at the edge after IDLE is re-entered.
- Reset in DONE: assert reset while res_valid=1 -> next edge: res_valid=0, res_data=0, gnt=0, busy=0, state IDLE; a fresh req=001 is granted to requester 0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one external 4x4
// unsigned multiplier. It registers the winner's operands, captures the
// product and holds it with the owner's index until the consumer acks.
module mul_share_arbiter #(
  parameter int unsigned N_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] a_in,
  input  logic [4*N_REQ-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [3:0]         mul_I1,
  output logic [3:0]         mul_I2,
  input  logic [7:0]         mul_P,
  output logic               res_valid,
  output logic [1:0]         res_id,
  output logic [7:0]         res_data,
  input  logic               res_ack,
  output logic               busy
);

  localparam int unsigned IDW = 2;
  localparam int unsigned OPW = 4;
  localparam int unsigned PW  = 8;
  localparam int unsigned SW  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;

  logic [N_REQ-1:0]   gnt_d;
  logic [OPW-1:0]     mul_i1_d, mul_i2_d;
  logic               res_valid_d;
  logic [IDW-1:0]     res_id_d;
  logic [PW-1:0]      res_data_d;
  logic               busy_d;

  logic [2*N_REQ-1:0] req_dbl_c;
  logic [N_REQ-1:0]   req_rot_c;
  logic [SW-1:0]      start_c;
  logic [IDW-1:0]     offset_c;
  logic [SW-1:0]      win_sum_c;
  logic [IDW-1:0]     win_c;

  // Winner search: rotate req so bit 0 is the requester after last_grant,
  // take the lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    start_c   = SW'(last_grant_q) + SW'(1);
    req_dbl_c = {req, req};
    req_rot_c = N_REQ'(req_dbl_c >> start_c);
    offset_c  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot_c[i]) offset_c = IDW'(i);
    end
    win_sum_c = start_c + SW'(offset_c);
    if (win_sum_c >= SW'(N_REQ)) win_sum_c = win_sum_c - SW'(N_REQ);
    win_c = IDW'(win_sum_c);
  end

  // Next-state and next-output logic; every register holds unless told otherwise.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = '0;
    mul_i1_d     = mul_I1;
    mul_i2_d     = mul_I2;
    res_valid_d  = res_valid;
    res_id_d     = res_id;
    res_data_d   = res_data;
    busy_d       = busy;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d    = N_REQ'(1) << win_c;
          mul_i1_d = OPW'(a_in >> {win_c, 2'b00});
          mul_i2_d = OPW'(b_in >> {win_c, 2'b00});
          res_id_d = win_c;
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        res_data_d   = mul_P;
        res_valid_d  = 1'b1;
        last_grant_d = res_id;
        state_d      = DONE;
      end
      DONE: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      gnt          <= '0;
      mul_I1       <= '0;
      mul_I2       <= '0;
      res_valid    <= 1'b0;
      res_id       <= '0;
      res_data     <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt          <= gnt_d;
      mul_I1       <= mul_i1_d;
      mul_I2       <= mul_i2_d;
      res_valid    <= res_valid_d;
      res_id       <= res_id_d;
      res_data     <= res_data_d;
      busy         <= busy_d;
    end
  end

endmodule
